// File: rtl/exp_pkg.sv
// Shared fixed-point constants and types for the exponential pipeline
// (range reduction, series evaluation, scaling).
package exp_pkg;

  localparam int IN_W_DEF   = 32;
  localparam int FRAC_W_DEF = 16;
  localparam int K_W_DEF    = 8;

  // round(ln2 * 2^16) and round(2^16 / ln2), both tied to FRAC_W_DEF = 16
  localparam int LN2_Q      = 45426;
  localparam int INV_LN2_Q  = 94548;

  typedef logic signed [IN_W_DEF-1:0] fx_t;
  typedef logic signed [K_W_DEF-1:0]  k_t;

endpackage

// File: rtl/exp_rr_correct.sv
// Combinational second stage of range reduction: r0 = x - k0*ln2, one-step
// correction into [0, ln2), then k narrowing (saturating when EXP_RR_OVF_EN is defined).
module exp_rr_correct
  import exp_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int K_W    = K_W_DEF,
  parameter int K0_W   = IN_W - FRAC_W + 2
) (
  input  logic signed [IN_W-1:0] i_x,
  input  logic signed [K0_W-1:0] i_k0,
  output logic signed [K_W-1:0]  o_k,
  output logic signed [IN_W-1:0] o_r,
  output logic                   o_ovf
);

  localparam int R0_W = K0_W + FRAC_W + 3;
  localparam int KC_W = K0_W + 1;
  localparam logic signed [KC_W-1:0] K_ONE = {{(KC_W-1){1'b0}}, 1'b1};

  logic signed [FRAC_W+1:0] w_ln2;
  logic signed [R0_W-1:0]   w_ln2_ext;
  logic signed [R0_W-1:0]   w_r0;
  logic signed [KC_W-1:0]   w_k0_ext;
  logic signed [R0_W-1:0]   w_rc;
  logic signed [KC_W-1:0]   w_kc;

  assign w_ln2     = (FRAC_W+2)'(LN2_Q);
  assign w_ln2_ext = R0_W'(w_ln2);
  assign w_k0_ext  = KC_W'(i_k0);
  assign w_r0      = R0_W'(i_x) - R0_W'(i_k0) * w_ln2_ext;

  // The floor estimate from the multiply can be off by one in either direction
  always_comb begin
    w_rc = w_r0;
    w_kc = w_k0_ext;
    if (w_r0[R0_W-1]) begin
      w_rc = w_r0 + w_ln2_ext;
      w_kc = w_k0_ext - K_ONE;
    end else if (w_r0 >= w_ln2_ext) begin
      w_rc = w_r0 - w_ln2_ext;
      w_kc = w_k0_ext + K_ONE;
    end else begin
      w_rc = w_r0;
      w_kc = w_k0_ext;
    end
  end

`ifdef EXP_RR_OVF_EN
  localparam logic signed [KC_W-1:0] K_MAX = {{(KC_W-K_W+1){1'b0}}, {(K_W-1){1'b1}}};
  localparam logic signed [KC_W-1:0] K_MIN = {{(KC_W-K_W+1){1'b1}}, {(K_W-1){1'b0}}};

  // Clamp k to the output range; a clamped k makes r meaningless, so zero it
  always_comb begin
    o_k   = K_W'(w_kc);
    o_r   = IN_W'(w_rc);
    o_ovf = 1'b0;
    if (w_kc > K_MAX) begin
      o_k   = {1'b0, {(K_W-1){1'b1}}};
      o_r   = {IN_W{1'b0}};
      o_ovf = 1'b1;
    end else if (w_kc < K_MIN) begin
      o_k   = {1'b1, {(K_W-1){1'b0}}};
      o_r   = {IN_W{1'b0}};
      o_ovf = 1'b1;
    end else begin
      o_k   = K_W'(w_kc);
      o_r   = IN_W'(w_rc);
      o_ovf = 1'b0;
    end
  end
`else
  assign o_k   = K_W'(w_kc);
  assign o_r   = IN_W'(w_rc);
  assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/exp_range_reduce.sv
// Range reduction x = k*ln2 + r, 0 <= r < ln2, as a 2-stage valid/ready pipeline.
// Optional k saturation and out_ovf port under EXP_RR_OVF_EN.
module exp_range_reduce
  import exp_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int K_W    = K_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [K_W-1:0]  out_k,
  output logic signed [IN_W-1:0] out_r
`ifdef EXP_RR_OVF_EN
  ,
  output logic                   out_ovf
`endif
);

  localparam int P_W  = IN_W + FRAC_W + 2;
  localparam int K0_W = P_W - 2*FRAC_W;

  logic signed [FRAC_W+1:0] w_inv;
  logic signed [P_W-1:0]    w_p;
  logic signed [K0_W-1:0]   w_k0;
  logic                     w_s2_adv;
  logic signed [K_W-1:0]    w_k;
  logic signed [IN_W-1:0]   w_r;
  logic                     w_ovf;

  logic                     r_s1_valid;
  logic signed [IN_W-1:0]   r_s1_x;
  logic signed [K0_W-1:0]   r_s1_k0;
  logic                     r_out_valid;
  logic signed [K_W-1:0]    r_out_k;
  logic signed [IN_W-1:0]   r_out_r;
  logic                     r_out_ovf;

  // x/ln2 in fixed point; dropping 2*FRAC_W bits with >>> is a floor
  assign w_inv    = (FRAC_W+2)'(INV_LN2_Q);
  assign w_p      = P_W'(in_x) * P_W'(w_inv);
  assign w_k0     = K0_W'(w_p >>> (2*FRAC_W));

  assign w_s2_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;

  exp_rr_correct #(
    .IN_W   (IN_W),
    .FRAC_W (FRAC_W),
    .K_W    (K_W),
    .K0_W   (K0_W)
  ) u_correct (
    .i_x   (r_s1_x),
    .i_k0  (r_s1_k0),
    .o_k   (w_k),
    .o_r   (w_r),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= {IN_W{1'b0}};
      r_s1_k0    <= {K0_W{1'b0}};
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      r_s1_x     <= in_x;
      r_s1_k0    <= w_k0;
    end
  end

  // Output register only moves when empty or drained, so it holds under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_k     <= {K_W{1'b0}};
      r_out_r     <= {IN_W{1'b0}};
      r_out_ovf   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      r_out_k     <= w_k;
      r_out_r     <= w_r;
      r_out_ovf   <= w_ovf;
    end
  end

  assign out_valid = r_out_valid;
  assign out_k     = r_out_k;
  assign out_r     = r_out_r;
`ifdef EXP_RR_OVF_EN
  assign out_ovf   = r_out_ovf;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = r_out_ovf;
`endif

endmodule

// File: tb/tb_exp_range_reduce.sv
// Scoreboard bench for exp_range_reduce: reference is k = floor(x / LN2_Q), r = x - k*LN2_Q
// on plain integers, with k saturation or wrapping depending on EXP_RR_OVF_EN.
module tb_exp_range_reduce;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_x;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_k;
  logic [31:0]        out_r;
  logic               ovf_obs;

  always #5 clk = ~clk;

`ifdef EXP_RR_OVF_EN
  exp_range_reduce dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_k(out_k), .out_r(out_r),
    .out_ovf(ovf_obs)
  );
`else
  exp_range_reduce dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_k(out_k), .out_r(out_r)
  );
  assign ovf_obs = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] x;
    logic [7:0]  k;
    logic [31:0] r;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   pops        = 0;
  int   ready_mode  = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random
  logic        held     = 1'b0;
  logic [40:0] held_val = '0;

  function automatic exp_t model(input logic signed [31:0] x);
    longint xl, quo, rem;
    exp_t   e;
    xl  = longint'(x);
    quo = xl / 64'sd45426;
    rem = xl - quo * 64'sd45426;
    if (rem < 0) begin
      quo = quo - 1;
      rem = rem + 64'sd45426;
    end
    e.x   = x;
    e.ovf = 1'b0;
`ifdef EXP_RR_OVF_EN
    if (quo > 127) begin
      e.k = 8'h7f; e.r = 32'd0; e.ovf = 1'b1;
    end else if (quo < -128) begin
      e.k = 8'h80; e.r = 32'd0; e.ovf = 1'b1;
    end else begin
      e.k = quo[7:0]; e.r = rem[31:0];
    end
`else
    e.k = quo[7:0];
    e.r = rem[31:0];
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor + scoreboard: handshakes are decided by values stable at the falling edge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held)
        chk("hold_stable", 64'({out_valid, out_k, out_r, ovf_obs}), 64'({1'b1, held_val}));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(out_valid), 64'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          pops++;
          chk($sformatf("k x=%0d", $signed(e.x)), 64'(out_k), 64'(e.k));
          chk($sformatf("r x=%0d", $signed(e.x)), 64'(out_r), 64'(e.r));
          chk($sformatf("ovf x=%0d", $signed(e.x)), 64'(ovf_obs), 64'(e.ovf));
        end
      end
      held     = out_valid && !out_ready;
      held_val = {out_k, out_r, ovf_obs};
      if (in_valid && in_ready) q.push_back(model(in_x));
    end
  end

  // out_ready driver, updated a little after each rising edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic signed [31:0] x, output int tries);
    bit ok;
    ok       = 1'b0;
    tries    = 0;
    in_valid = 1'b1;
    in_x     = x;
    while (!ok && tries < 60) begin
      @(negedge clk);
      ok = in_ready;
      tries++;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 64'(ok), 64'(1));
    in_valid = 1'b0;
  endtask

  initial begin
    int t;
    int p0;
    logic signed [31:0] dir [10];
    dir = '{32'sd65536, -32'sd65536, 32'sd45426, 32'sd45425, 32'sd6553600,
            -32'sd6553600, -32'sd1, 32'sd0, 32'h7fffffff, 32'h80000000};

    rst = 1'b1; in_valid = 1'b0; in_x = 32'sd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_k", 64'(out_k), 64'(0));
    chk("rst_out_r", 64'(out_r), 64'(0));
    chk("rst_out_ovf", 64'(ovf_obs), 64'(0));

    // Latency: x=0 presented, captured on the next edge, visible after the edge after that
    @(posedge clk); #1;
    in_valid = 1'b1; in_x = 32'sd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_edge1", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_edge2", 64'(out_valid), 64'(1));
    repeat (2) @(posedge clk); #1;

    foreach (dir[i]) send(dir[i], t);
    repeat (3) @(posedge clk); #1;

    // 8 back-to-back items: never stalled, all 8 out two edges after the last accept
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      send($signed($urandom_range(0, 2000000)) - 32'sd1000000, t);
      chk("b2b_no_stall", 64'(t), 64'(1));
    end
    repeat (2) @(posedge clk); #1;
    chk("b2b_count", 64'(pops - p0), 64'(8));

    // Backpressure: two items fill both stages, the third must wait
    ready_mode = 1;
    send(32'sd100000, t);
    send(-32'sd300000, t);
    in_valid = 1'b1; in_x = 32'sd777777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    ready_mode = 0;
    send(32'sd777777, t);
    repeat (4) @(posedge clk); #1;

    // Randomized stream with random backpressure and input gaps
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) send($signed($urandom), t);
      else send($signed($urandom_range(0, 32'h00ffffff)) - 32'sh00800000, t);
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end
    ready_mode = 0;
    for (int i = 0; i < 50 && q.size() != 0; i++) begin @(posedge clk); #1; end
    chk("random_drain", 64'(q.size()), 64'(0));

    // Reset with two items in flight: both discarded
    ready_mode = 1;
    send(32'sd65536, t);
    send(32'sd131072, t);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    ready_mode = 0;
    repeat (6) @(posedge clk); #1;
    chk("midrst_queue_empty", 64'(q.size()), 64'(0));
    send(-32'sd65536, t);
    for (int i = 0; i < 20 && q.size() != 0; i++) begin @(posedge clk); #1; end
    chk("final_drain", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
